// File: rtl/data_ram_ws.sv
// Single-port word RAM with byte-lane writes and a programmable wait-state count.
// Latency: completion (data_ready) LATENCY+1 edges after acceptance, then one RESP cycle.
// Backpressure: ce is only sampled in IDLE; the requester holds ce until data_ready to be served.
module data_ram_ws #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   sel,
    input  logic [DATA_W-1:0]     data_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  data_ready,
    output logic                  busy,
    output logic                  err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFS   = $clog2(NB);
    localparam int HI    = DEPTH_LOG2 + OFS;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    logic [3:0]            cnt;

    // request captured at acceptance; later input changes cannot disturb it
    logic                  l_we;
    logic [ADDR_W-1:0]     l_addr;
    logic [NB-1:0]         l_sel;
    logic [DATA_W-1:0]     l_data;

    logic [DATA_W-1:0]     mem [DEPTH];

    logic [DEPTH_LOG2-1:0] idx;
    logic                  oor;
    logic                  fire;

    // byte-offset bits only select within a word, which the lane enables already cover
    logic                  unused_lsb;
    assign unused_lsb = &{1'b0, l_addr[OFS-1:0]};

    assign idx  = l_addr[HI-1:OFS];
    assign fire = (state == WAIT) && (cnt == 4'd0);

    // any address bit above the memory's span marks the access as out of range
    generate
        if (ADDR_W > HI) begin : g_range
            assign oor = |l_addr[ADDR_W-1:HI];
        end else begin : g_norange
            assign oor = 1'b0;
        end
    endgenerate

    // capture the request on the accepting edge only
    always_ff @(posedge clk) begin
        if (state == IDLE && ce) begin
            l_we   <= we;
            l_addr <= addr;
            l_sel  <= sel;
            l_data <= data_i;
        end
    end

    // lane-masked write on the completion edge; reset on that edge suppresses it
    always_ff @(posedge clk) begin
        if (!rst && fire && l_we && !oor) begin
            for (int i = 0; i < NB; i++) begin
                if (l_sel[i]) begin
                    mem[idx][8*i +: 8] <= l_data[8*i +: 8];
                end
            end
        end
    end

    // access sequencer with registered status outputs and held read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            data_o     <= '0;
            data_ready <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (ce) begin
                        cnt   <= 4'(LATENCY);
                        state <= WAIT;
                        busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= RESP;
                        data_ready <= 1'b1;
                        err        <= oor;
                        // writes and faulted accesses return zero; reads return the whole word
                        if (oor || l_we) begin
                            data_o <= '0;
                        end else begin
                            data_o <= mem[idx];
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_ws.sv
`timescale 1ns/1ps
module tb_data_ram_ws;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    bit fin [3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // three configurations: (32b, LAT1), (64b, LAT3), (32b, LAT0)
    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int DW  = (g == 1) ? 64 : 32;
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        localparam int NB  = DW / 8;
        localparam int OFS = (DW == 64) ? 3 : 2;
        localparam int HI  = 10 + OFS;

        logic          rst, ce, we, data_ready, busy, err;
        logic [31:0]   addr;
        logic [NB-1:0] sel;
        logic [DW-1:0] data_i, data_o;

        data_ram_ws #(.DATA_W(DW), .ADDR_W(32), .DEPTH_LOG2(10), .LATENCY(LAT)) dut (
            .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
            .data_i(data_i), .data_o(data_o), .data_ready(data_ready),
            .busy(busy), .err(err)
        );

        // reference: memory image with per-byte "known" flags, access timed by edge number
        logic [DW-1:0] mm [1024];
        logic [NB-1:0] mk [1024];
        logic [DW-1:0] x_do;
        logic [NB-1:0] x_mk;
        bit            x_rdy, x_err, x_busy, live, act;
        int            n_edge, done_at;
        bit            m_we;
        logic [31:0]   m_addr;
        logic [NB-1:0] m_sel;
        logic [DW-1:0] m_dat;

        initial begin
            for (int i = 0; i < 1024; i++) mk[i] = '0;
            live = 0; act = 0; n_edge = 0; done_at = 0;
        end

        function automatic logic [DW-1:0] bmask(input logic [NB-1:0] m);
            logic [DW-1:0] r;
            for (int i = 0; i < NB; i++) r[8*i +: 8] = {8{m[i]}};
            return r;
        endfunction

        function automatic logic [DW-1:0] rep(input logic [31:0] x);
            logic [63:0] t;
            t = {x, x};
            return t[DW-1:0];
        endfunction

        function automatic logic [NB-1:0] srep(input logic [3:0] x);
            logic [7:0] t;
            t = {x, x};
            return t[NB-1:0];
        endfunction

        // compare outputs of the last rising edge, then predict the next one
        always @(negedge clk) begin
            int w;
            if (live) begin
                chk($sformatf("c%0d busy", g), busy, x_busy);
                chk($sformatf("c%0d data_ready", g), data_ready, x_rdy);
                chk($sformatf("c%0d err", g), err, x_err);
                chk($sformatf("c%0d data_o", g), data_o & bmask(x_mk), x_do & bmask(x_mk));
            end
            x_rdy = 0;
            x_err = 0;
            if (rst) begin
                live = 1; act = 0; x_busy = 0; x_do = '0; x_mk = '1;
            end else if (live) begin
                n_edge++;
                if (act && n_edge == done_at) begin
                    x_rdy = 1;
                    w = int'(m_addr[HI-1:OFS]);
                    if ((m_addr >> HI) != 0) begin
                        x_err = 1; x_do = '0; x_mk = '1;
                    end else if (m_we) begin
                        for (int i = 0; i < NB; i++) begin
                            if (m_sel[i]) begin
                                mm[w][8*i +: 8] = m_dat[8*i +: 8];
                                mk[w][i] = 1'b1;
                            end
                        end
                        x_do = '0; x_mk = '1;
                    end else begin
                        x_do = mm[w]; x_mk = mk[w];
                    end
                end else if (act && n_edge > done_at) begin
                    act = 0;
                end else if (!act && ce) begin
                    act = 1; done_at = n_edge + LAT + 1;
                    m_we = we; m_addr = addr; m_sel = sel; m_dat = data_i;
                end
                x_busy = act;
            end
        end

        task automatic wait_rdy(output bit got);
            got = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if (data_ready) got = 1;
            end
            chk($sformatf("c%0d ready seen", g), got, 1);
        endtask

        // one request from an idle DUT; returns read data, err and edges to completion
        task automatic acc(input bit w, input logic [31:0] a, input logic [NB-1:0] s,
                           input logic [DW-1:0] d, output logic [DW-1:0] q, output bit e);
            int  c0;
            bit  got;
            ce = 1; we = w; addr = a; sel = s; data_i = d; c0 = cyc;
            wait_rdy(got);
            chk($sformatf("c%0d latency", g), cyc - (c0 + 1), LAT + 1);
            q = data_o; e = err;
            @(posedge clk); #1;
            ce = 0;
        endtask

        initial begin
            logic [DW-1:0] q, q2, ex, t;
            logic [63:0]   t64;
            logic [NB-1:0] su;
            bit            e, got;
            int            c1, c2;
            rst = 1; ce = 0; we = 0; addr = '0; sel = '0; data_i = '0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk($sformatf("c%0d rst data_o", g), data_o, 0);
            chk($sformatf("c%0d rst busy", g), busy, 0);
            @(posedge clk); #1;
            rst = 0;
            @(posedge clk); #1;

            // full write then read back
            acc(1, 32'h10, '1, rep(32'hDEADBEEF), q, e);
            chk($sformatf("c%0d wr data_o", g), q, 0);
            acc(0, 32'h10, '0, '0, q, e);
            chk($sformatf("c%0d rd 0x10", g), q, rep(32'hDEADBEEF));

            // alternate byte lanes
            acc(1, 32'h20, '1, rep(32'h11223344), q, e);
            acc(1, 32'h20, srep(4'b0101), rep(32'hAABBCCDD), q, e);
            acc(0, 32'h20, '1, '0, q, e);
            chk($sformatf("c%0d lanes", g), q, rep(32'h11BB33DD));

            // out of range aliases onto word 0 but must not touch it
            acc(1, 32'h0, '1, rep(32'h0BADF00D), q, e);
            acc(0, 32'h1 << HI, '1, '0, q, e);
            chk($sformatf("c%0d oor rd err", g), e, 1);
            chk($sformatf("c%0d oor rd data", g), q, 0);
            acc(1, 32'h1 << HI, '1, '1, q, e);
            chk($sformatf("c%0d oor wr err", g), e, 1);
            acc(0, 32'h0, '1, '0, q, e);
            chk($sformatf("c%0d word0 kept", g), q, rep(32'h0BADF00D));

            // upper-half lanes only
            t64 = 64'h0123456789ABCDEF;
            t = t64[DW-1:0];
            su = '0;
            for (int i = NB/2; i < NB; i++) su[i] = 1'b1;
            acc(1, 32'h08, '1, rep(32'h5A5A5A5A), q, e);
            acc(1, 32'h08, su, t, q, e);
            acc(0, 32'h08, '0, '0, q, e);
            ex = rep(32'h5A5A5A5A);
            ex[DW-1:DW/2] = t[DW-1:DW/2];
            chk($sformatf("c%0d upper half", g), q, ex);

            // reset one cycle after acceptance aborts the write
            acc(1, 32'h40, '1, rep(32'hCAFEF00D), q, e);
            ce = 1; we = 1; addr = 32'h40; sel = '1; data_i = DW'(32'h55);
            @(posedge clk); #1;
            rst = 1; ce = 0;
            @(posedge clk); #1;
            rst = 0;
            for (int k = 0; k < LAT + 4; k++) begin
                @(negedge clk);
                chk($sformatf("c%0d abort no ready", g), data_ready, 0);
            end
            @(posedge clk); #1;
            acc(0, 32'h40, '1, '0, q, e);
            chk($sformatf("c%0d abort kept", g), q, rep(32'hCAFEF00D));

            // ce held across two reads
            ce = 1; we = 0; addr = 32'h10; sel = '0;
            wait_rdy(got);
            c1 = cyc; q = data_o;
            @(posedge clk); #1;
            addr = 32'h20;
            wait_rdy(got);
            c2 = cyc; q2 = data_o;
            @(posedge clk); #1;
            ce = 0;
            chk($sformatf("c%0d held spacing", g), c2 - c1, LAT + 3);
            chk($sformatf("c%0d held rd1", g), q, rep(32'hDEADBEEF));
            chk($sformatf("c%0d held rd2", g), q2, rep(32'h11BB33DD));

            // random traffic including ignored ce, input churn and sporadic reset
            for (int n = 0; n < 1500; n++) begin
                @(posedge clk); #1;
                rst = ($urandom_range(0, 63) == 0);
                ce  = 1'($urandom_range(0, 1));
                we  = 1'($urandom_range(0, 1));
                addr = ($urandom_range(0, 15) << OFS) | $urandom_range(0, NB - 1);
                if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(HI, 31));
                sel = NB'($urandom);
                t64 = {$urandom, $urandom};
                data_i = t64[DW-1:0];
            end
            @(posedge clk); #1;
            rst = 0; ce = 0;
            repeat (LAT + 6) @(posedge clk);
            fin[g] = 1;
        end
    end

    initial begin
        int k;
        k = 0;
        while (!(fin[0] && fin[1] && fin[2]) && k < 20000) begin
            @(posedge clk);
            k++;
        end
        chk("all configs done", fin[0] & fin[1] & fin[2], 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
